// File: rtl/demux_rr.sv
// One-to-N demultiplexer with a one-entry register per output channel.
// MODE 0 dispatches round-robin via an internal pointer; MODE 1 steers by sel_in.
module demux_rr #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned MODE   = 0
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      valid_in,
  input  logic [$clog2(NUM_CH)-1:0] sel_in,
  output logic                      ready_out,
  output logic [NUM_CH*DATA_W-1:0]  data_out,
  output logic [NUM_CH-1:0]         valid_out,
  input  logic [NUM_CH-1:0]         ready_in,
  output logic [$clog2(NUM_CH)-1:0] ptr_out,
  output logic [15:0]               acc_count
);

  localparam int unsigned SelW = $clog2(NUM_CH);

  logic [NUM_CH*DATA_W-1:0] data_q, data_d;
  logic [NUM_CH-1:0]        valid_q, valid_d;
  logic [SelW-1:0]          ptr_q, ptr_d;
  logic [15:0]              acc_q, acc_d;

  logic [SelW-1:0]   target;
  logic [NUM_CH-1:0] ch_free;
  logic              xfer;

  // A channel is free if empty or being drained on this same edge.
  always_comb begin
    target    = (MODE == 0) ? ptr_q : sel_in;
    ch_free   = ~valid_q | ready_in;
    ready_out = reset_L & ch_free[target];
    xfer      = valid_in & ready_out;
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~ready_in;
    ptr_d   = ptr_q;
    acc_d   = acc_q;
    if (xfer) begin
      data_d[target*DATA_W +: DATA_W] = data_in;
      valid_d[target]                 = 1'b1;
      acc_d                           = acc_q + 16'd1;
      if (MODE == 0) begin
        ptr_d = (ptr_q == SelW'(NUM_CH - 1)) ? '0 : ptr_q + SelW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_q  <= '0;
      valid_q <= '0;
      ptr_q   <= '0;
      acc_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      acc_q   <= acc_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign ptr_out   = ptr_q;
  assign acc_count = acc_q;

endmodule

// File: tb/tb_demux_rr.sv
// Directed bench for demux_rr: three instances (MODE0/2ch, MODE0/4ch, MODE1/4ch)
// share clock and reset; each step compares against hand-computed values.
module tb_demux_rr;

  logic clk;
  logic reset_L;

  logic [7:0]  a_data;
  logic        a_valid;
  logic [0:0]  a_sel;
  logic        a_ready_out;
  logic [15:0] a_dout;
  logic [1:0]  a_vout;
  logic [1:0]  a_ready_in;
  logic [0:0]  a_ptr;
  logic [15:0] a_acc;

  logic [7:0]  b_data;
  logic        b_valid;
  logic [1:0]  b_sel;
  logic        b_ready_out;
  logic [31:0] b_dout;
  logic [3:0]  b_vout;
  logic [3:0]  b_ready_in;
  logic [1:0]  b_ptr;
  logic [15:0] b_acc;

  logic [7:0]  c_data;
  logic        c_valid;
  logic [1:0]  c_sel;
  logic        c_ready_out;
  logic [31:0] c_dout;
  logic [3:0]  c_vout;
  logic [3:0]  c_ready_in;
  logic [1:0]  c_ptr;
  logic [15:0] c_acc;

  int n_cmp = 0;
  int n_err = 0;

  demux_rr #(.DATA_W(8), .NUM_CH(2), .MODE(0)) u_a (
    .clk(clk), .reset_L(reset_L), .data_in(a_data), .valid_in(a_valid), .sel_in(a_sel),
    .ready_out(a_ready_out), .data_out(a_dout), .valid_out(a_vout), .ready_in(a_ready_in),
    .ptr_out(a_ptr), .acc_count(a_acc)
  );

  demux_rr #(.DATA_W(8), .NUM_CH(4), .MODE(0)) u_b (
    .clk(clk), .reset_L(reset_L), .data_in(b_data), .valid_in(b_valid), .sel_in(b_sel),
    .ready_out(b_ready_out), .data_out(b_dout), .valid_out(b_vout), .ready_in(b_ready_in),
    .ptr_out(b_ptr), .acc_count(b_acc)
  );

  demux_rr #(.DATA_W(8), .NUM_CH(4), .MODE(1)) u_c (
    .clk(clk), .reset_L(reset_L), .data_in(c_data), .valid_in(c_valid), .sel_in(c_sel),
    .ready_out(c_ready_out), .data_out(c_dout), .valid_out(c_vout), .ready_in(c_ready_in),
    .ptr_out(c_ptr), .acc_count(c_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_L = 1'b0;
    a_data = '0; a_valid = 1'b0; a_sel = '0; a_ready_in = 2'b11;
    b_data = '0; b_valid = 1'b0; b_sel = '0; b_ready_in = 4'b1111;
    c_data = '0; c_valid = 1'b0; c_sel = '0; c_ready_in = 4'b1111;
    #1;
    chk("rst_a_vout", a_vout, 0);
    chk("rst_a_dout", a_dout, 0);
    chk("rst_a_ptr", a_ptr, 0);
    chk("rst_a_acc", a_acc, 0);
    chk("rst_a_ready", a_ready_out, 0);
    chk("rst_b_ready", b_ready_out, 0);
    #11 reset_L = 1'b1;
    tick();

    // 2-channel round-robin stream, all downstream ready
    a_valid = 1'b1; a_data = 8'hA1;
    #1 chk("a_ready0", a_ready_out, 1);
    tick();
    chk("a_e1_vout", a_vout, 2'b01);
    chk("a_e1_dout", a_dout, 16'h00A1);
    chk("a_e1_ptr", a_ptr, 1);
    a_data = 8'hA2; tick();
    chk("a_e2_vout", a_vout, 2'b10);
    chk("a_e2_dout", a_dout, 16'hA2A1);
    chk("a_e2_ptr", a_ptr, 0);
    a_data = 8'hA3; tick();
    chk("a_e3_vout", a_vout, 2'b01);
    chk("a_e3_dout", a_dout, 16'hA2A3);
    a_data = 8'hA4; tick();
    chk("a_e4_vout", a_vout, 2'b10);
    chk("a_e4_dout", a_dout, 16'hA4A3);
    chk("a_e4_acc", a_acc, 4);
    a_valid = 1'b0; tick();
    chk("a_idle_vout", a_vout, 2'b00);
    chk("a_idle_acc", a_acc, 4);
    chk("a_idle_ptr", a_ptr, 0);

    // Reload a channel on the same edge it is drained
    a_ready_in = 2'b00; a_valid = 1'b1; a_data = 8'h55; tick();
    chk("a_55_dout", a_dout, 16'hA455);
    a_data = 8'h77; tick();
    chk("a_77_vout", a_vout, 2'b11);
    chk("a_77_dout", a_dout, 16'h7755);
    chk("a_77_ptr", a_ptr, 0);
    a_data = 8'h66;
    #1 chk("a_nofree_ready", a_ready_out, 0);
    a_ready_in = 2'b01;
    #1 chk("a_reload_ready", a_ready_out, 1);
    tick();
    chk("a_reload_vout", a_vout, 2'b11);
    chk("a_reload_dout", a_dout, 16'h7766);
    chk("a_reload_acc", a_acc, 7);
    a_valid = 1'b0; a_ready_in = 2'b00;

    // 4-channel round-robin with channel 2 blocked
    b_ready_in = 4'b1011; b_valid = 1'b1;
    b_data = 8'h10; tick();
    chk("b_10_vout", b_vout, 4'b0001);
    b_data = 8'h11; tick();
    b_data = 8'h12; tick();
    chk("b_12_vout", b_vout, 4'b0100);
    chk("b_12_dout", b_dout, 32'h0012_1110);
    b_data = 8'h13; tick();
    chk("b_13_vout", b_vout, 4'b1100);
    chk("b_13_ptr", b_ptr, 0);
    b_data = 8'h14; tick();
    b_data = 8'h15; tick();
    chk("b_15_dout", b_dout, 32'h1312_1514);
    chk("b_15_ptr", b_ptr, 2);
    b_data = 8'h16;
    #1 chk("b_stall_ready", b_ready_out, 0);
    tick();
    chk("b_stall_vout", b_vout, 4'b0100);
    chk("b_stall_dout", b_dout, 32'h1312_1514);
    chk("b_stall_ptr", b_ptr, 2);
    chk("b_stall_acc", b_acc, 6);
    b_valid = 1'b0;
    #1 chk("b_novalid_ready", b_ready_out, 0);
    b_ready_in = 4'b1111;
    #1 chk("b_open_ready_novalid", b_ready_out, 1);
    b_valid = 1'b1; tick();
    chk("b_16_vout", b_vout, 4'b0100);
    chk("b_16_dout", b_dout, 32'h1316_1514);
    chk("b_16_ptr", b_ptr, 3);
    b_data = 8'h17; tick();
    chk("b_17_dout", b_dout, 32'h1716_1514);
    chk("b_17_ptr", b_ptr, 0);
    chk("b_17_acc", b_acc, 8);
    b_valid = 1'b0;

    // Steered mode with channel 3 blocked
    c_ready_in = 4'b0111; c_valid = 1'b1; c_sel = 2'd3; c_data = 8'h31;
    #1 chk("c_first_ready", c_ready_out, 1);
    tick();
    chk("c_31_vout", c_vout, 4'b1000);
    chk("c_31_dout", c_dout, 32'h3100_0000);
    c_data = 8'h32;
    #1 chk("c_stall_ready", c_ready_out, 0);
    tick();
    chk("c_stall_dout", c_dout, 32'h3100_0000);
    chk("c_stall_acc", c_acc, 1);
    c_sel = 2'd0;
    #1 chk("c_sel0_ready", c_ready_out, 1);
    tick();
    chk("c_32_vout", c_vout, 4'b1001);
    chk("c_32_dout", c_dout, 32'h3100_0032);
    chk("c_32_ptr", c_ptr, 0);
    chk("c_32_acc", c_acc, 2);
    c_valid = 1'b0;

    // Held entries on u_a, then asynchronous reset between edges
    chk("a_hold_vout", a_vout, 2'b11);
    chk("a_hold_dout", a_dout, 16'h7766);
    #2 reset_L = 1'b0;
    #1;
    chk("mid_a_vout", a_vout, 0);
    chk("mid_a_dout", a_dout, 0);
    chk("mid_a_ptr", a_ptr, 0);
    chk("mid_a_acc", a_acc, 0);
    chk("mid_a_ready", a_ready_out, 0);
    chk("mid_b_dout", b_dout, 0);
    chk("mid_c_vout", c_vout, 0);
    #1 reset_L = 1'b1;
    tick();
    a_ready_in = 2'b11; a_valid = 1'b1; a_data = 8'hC0; tick();
    chk("post_vout", a_vout, 2'b01);
    chk("post_dout", a_dout, 16'h00C0);
    chk("post_acc", a_acc, 1);

    // Counter wrap
    for (int i = 0; i < 65534; i++) tick();
    chk("wrap_pre_acc", a_acc, 16'hFFFF);
    chk("wrap_pre_ptr", a_ptr, 1);
    tick();
    chk("wrap_acc", a_acc, 0);
    chk("wrap_ptr", a_ptr, 0);
    a_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
